// File: rtl/ps2_pkg.sv
// Shared types and default prefix values for the PS/2 scan-code sequencer.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXT    = 2'd1,
    ST_BRK    = 2'd2,
    ST_EXTBRK = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Event code field is wide enough for any byte width up to 16 bits.
  localparam int PS2_EV_W = 16;

  typedef struct packed {
    logic [PS2_EV_W-1:0] code;
    logic                ext;
    logic                brk;
  } key_event_t;

endpackage

// File: rtl/ps2_scancode_fsm_if.sv
// Byte-in / key-event-out bundle between the PS/2 receiver, sequencer and command logic.
interface ps2_scancode_fsm_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              key_valid;
  logic [DATA_W-1:0] key_code;
  logic              key_ext;
  logic              key_break;
  logic              seq_err;
  logic              busy;

  modport master (
    output data_in, data_valid,
    input  key_valid, key_code, key_ext, key_break, seq_err, busy
  );

  modport slave (
    input  data_in, data_valid,
    output key_valid, key_code, key_ext, key_break, seq_err, busy
  );
endinterface

// File: rtl/ps2_repeat_filter.sv
// Drops typematic repeats: remembers the last emitted make and suppresses an identical one.
// Only instantiated when REPEAT_FILTER_EN is defined.
module ps2_repeat_filter
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_valid,
  input  key_event_t ev,
  output logic       pass
);

  logic                last_valid_r;
  logic [PS2_EV_W-1:0] last_code_r;
  logic                last_ext_r;
  logic                same_s;

  assign same_s = last_valid_r && (last_code_r == ev.code) && (last_ext_r == ev.ext);
  assign pass   = !(same_s && !ev.brk);

  // last_make storage: load on a fresh make, invalidate on its matching break
  always_ff @(posedge clk) begin
    if (reset) begin
      last_valid_r <= 1'b0;
      last_code_r  <= '0;
      last_ext_r   <= 1'b0;
    end else if (ev_valid && !ev.brk && !same_s) begin
      last_valid_r <= 1'b1;
      last_code_r  <= ev.code;
      last_ext_r   <= ev.ext;
    end else if (ev_valid && ev.brk && same_s) begin
      last_valid_r <= 1'b0;
    end else begin
      last_valid_r <= last_valid_r;
    end
  end

endmodule

// File: rtl/ps2_scancode_fsm.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into one registered key event per code.
// Optional typematic repeat suppression under `define REPEAT_FILTER_EN.
module ps2_scancode_fsm
  import ps2_pkg::*;
#(
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] PREFIX_EXT     = DATA_W'(PS2_PREFIX_EXT),
  parameter logic [DATA_W-1:0] PREFIX_BRK     = DATA_W'(PS2_PREFIX_BRK),
  parameter int                TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               reset,
  ps2_scancode_fsm_if.slave  bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_t        state_r;
  ps2_state_t        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              is_ext_s;
  logic              is_brk_s;
  logic              expire_s;
  logic              emit_s;
  logic              err_s;
  logic              ev_ext_s;
  logic              ev_brk_s;
  logic              pass_s;
  logic              key_valid_r;
  logic [DATA_W-1:0] key_code_r;
  logic              key_ext_r;
  logic              key_break_r;
  logic              seq_err_r;
  logic              busy_r;

  assign is_ext_s = (bus.data_in == PREFIX_EXT);
  assign is_brk_s = (bus.data_in == PREFIX_BRK);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire_s = (state_r != ST_IDLE) && !bus.data_valid && (cnt_r == CNT_LAST);

  // Next-state and event decode for the current byte / timeout
  always_comb begin
    state_nxt_s = state_r;
    emit_s      = 1'b0;
    err_s       = 1'b0;
    ev_ext_s    = 1'b0;
    ev_brk_s    = 1'b0;
    if (bus.data_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (is_ext_s) begin
            state_nxt_s = ST_EXT;
          end else if (is_brk_s) begin
            state_nxt_s = ST_BRK;
          end else begin
            emit_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (is_brk_s) begin
            state_nxt_s = ST_EXTBRK;
          end else if (is_ext_s) begin
            err_s       = 1'b1;
            state_nxt_s = ST_EXT;
          end else begin
            emit_s      = 1'b1;
            ev_ext_s    = 1'b1;
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BRK, ST_EXTBRK: begin
          if (is_ext_s) begin
            err_s       = 1'b1;
            state_nxt_s = ST_EXT;
          end else if (is_brk_s) begin
            err_s       = 1'b1;
            state_nxt_s = ST_BRK;
          end else begin
            emit_s      = 1'b1;
            ev_brk_s    = 1'b1;
            ev_ext_s    = (state_r == ST_EXTBRK);
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else if (expire_s) begin
      err_s       = 1'b1;
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_r;
    end
  end

`ifdef REPEAT_FILTER_EN
  key_event_t filt_ev_s;

  assign filt_ev_s = '{code: PS2_EV_W'(bus.data_in), ext: ev_ext_s, brk: ev_brk_s};

  ps2_repeat_filter u_repeat_filter (
    .clk      (clk),
    .reset    (reset),
    .ev_valid (emit_s),
    .ev       (filt_ev_s),
    .pass     (pass_s)
  );
`else
  assign pass_s = 1'b1;
`endif

  // State, timeout counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      key_valid_r <= 1'b0;
      key_code_r  <= '0;
      key_ext_r   <= 1'b0;
      key_break_r <= 1'b0;
      seq_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      key_valid_r <= emit_s && pass_s;
      seq_err_r   <= err_s;
      if (emit_s && pass_s) begin
        key_code_r  <= bus.data_in;
        key_ext_r   <= ev_ext_s;
        key_break_r <= ev_brk_s;
      end else begin
        key_code_r  <= key_code_r;
      end
      if (bus.data_valid || (state_r == ST_IDLE) || expire_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.key_valid = key_valid_r;
  assign bus.key_code  = key_code_r;
  assign bus.key_ext   = key_ext_r;
  assign bus.key_break = key_break_r;
  assign bus.seq_err   = seq_err_r;
  assign bus.busy      = busy_r;

endmodule
